// File: rtl/dotl_pkg.sv
// Shared constants and types for the dice/traffic-light session scheduler.
package dotl_pkg;

    localparam int RES_W = 3;
    localparam int CNT_W = 8;

    localparam logic SEL_DICE  = 1'b1;
    localparam logic SEL_LIGHT = 1'b0;

    // Grant vector bit positions
    localparam int GNT_DICE  = 0;
    localparam int GNT_LIGHT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PRESS   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter load value for a hold length; a hold of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] hold_load(input int hold);
        if (hold <= 1) return '0;
        return CNT_W'(hold - 1);
    endfunction

endpackage

// File: rtl/dotl_rr_arb.sv
// Two-way round-robin arbiter: the side that did not win last time wins a tie.
import dotl_pkg::*;

module dotl_rr_arb (
    input  logic       i_pend_dice,
    input  logic       i_pend_light,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    logic w_both;

    assign w_both = i_pend_dice & i_pend_light;

    always_comb begin
        o_grant = '0;
        if (w_both) begin
            o_grant[GNT_DICE]  = (i_last_grant == SEL_LIGHT);
            o_grant[GNT_LIGHT] = (i_last_grant == SEL_DICE);
        end else begin
            o_grant[GNT_DICE]  = i_pend_dice;
            o_grant[GNT_LIGHT] = i_pend_light;
        end
    end

endmodule

// File: rtl/dotl_sched.sv
// Shares one dice/traffic-light block between two requesters: select mode,
// hold the button for a programmed time, release, capture the result.
import dotl_pkg::*;

module dotl_sched #(
    parameter int HOLD_DICE  = 5,
    parameter int HOLD_LIGHT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dice_req,
    input  logic             light_req,
    input  logic [RES_W-1:0] result,
    output logic             sel,
    output logic             button,
    output logic             busy,
    output logic             dice_done,
    output logic [RES_W-1:0] dice_val,
    output logic             light_done,
    output logic [RES_W-1:0] light_val
);

    localparam logic [CNT_W-1:0] LD_DICE  = hold_load(HOLD_DICE);
    localparam logic [CNT_W-1:0] LD_LIGHT = hold_load(HOLD_LIGHT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic             r_button;
    logic             r_last;
    logic             r_pend_dice;
    logic             r_pend_light;
    logic             r_dice_done;
    logic             r_light_done;
    logic [RES_W-1:0] r_dice_val;
    logic [RES_W-1:0] r_light_val;

    logic [1:0]       w_grant;
    logic             w_take_dice;
    logic             w_take_light;

    dotl_rr_arb u_arb (
        .i_pend_dice  (r_pend_dice),
        .i_pend_light (r_pend_light),
        .i_last_grant (r_last),
        .o_grant      (w_grant)
    );

    assign w_take_dice  = (r_state == IDLE) & w_grant[GNT_DICE];
    assign w_take_light = (r_state == IDLE) & w_grant[GNT_LIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sel        <= SEL_LIGHT;
            r_button     <= 1'b0;
            r_last       <= SEL_LIGHT;
            r_pend_dice  <= 1'b0;
            r_pend_light <= 1'b0;
            r_dice_done  <= 1'b0;
            r_light_done <= 1'b0;
            r_dice_val   <= '0;
            r_light_val  <= '0;
        end else begin
            r_dice_done  <= 1'b0;
            r_light_done <= 1'b0;
            // A request on its own grant edge survives and is served again later
            r_pend_dice  <= (r_pend_dice  & ~w_take_dice)  | dice_req;
            r_pend_light <= (r_pend_light & ~w_take_light) | light_req;

            case (r_state)
                IDLE: begin
                    if (w_take_dice) begin
                        r_sel   <= SEL_DICE;
                        r_last  <= SEL_DICE;
                        r_state <= SELECT;
                    end else if (w_take_light) begin
                        r_sel   <= SEL_LIGHT;
                        r_last  <= SEL_LIGHT;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    r_button <= 1'b1;
                    r_cnt    <= (r_sel == SEL_DICE) ? LD_DICE : LD_LIGHT;
                    r_state  <= PRESS;
                end
                PRESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_button <= 1'b0;
                        r_state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (r_sel == SEL_DICE) begin
                        r_dice_val  <= result;
                        r_dice_done <= 1'b1;
                    end else begin
                        r_light_val  <= result;
                        r_light_done <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel        = r_sel;
    assign button     = r_button;
    assign busy       = (r_state != IDLE);
    assign dice_done  = r_dice_done;
    assign dice_val   = r_dice_val;
    assign light_done = r_light_done;
    assign light_val  = r_light_val;

endmodule

// File: tb/tb_dotl_sched.sv
// Scoreboard bench for dotl_sched: sessions queued at stimulus, checked at done.
module tb_dotl_sched;

    localparam int HD = 5;
    localparam int HL = 1;

    typedef struct {
        logic       dice;
        logic [2:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dice_req = 1'b0;
    logic       light_req = 1'b0;
    logic [2:0] result;
    logic       sel, button, busy, dice_done, light_done;
    logic [2:0] dice_val, light_val;

    logic [2:0] dice_res = 3'd0;
    logic [2:0] light_res = 3'd0;
    logic       tb_last = 1'b0;   // 1 = dice granted last
    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         hcnt  = 0;

    always #5 clk = ~clk;

    // Emulated shared block: result depends on the selected mode
    assign result = sel ? dice_res : light_res;

    dotl_sched #(.HOLD_DICE(HD), .HOLD_LIGHT(HL)) dut (
        .clk        (clk),
        .rst        (rst),
        .dice_req   (dice_req),
        .light_req  (light_req),
        .result     (result),
        .sel        (sel),
        .button     (button),
        .busy       (busy),
        .dice_done  (dice_done),
        .dice_val   (dice_val),
        .light_done (light_done),
        .light_val  (light_val)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d);
        exp_t e;
        e.dice = d;
        e.val  = d ? dice_res : light_res;
        q.push_back(e);
        tb_last = d;
    endtask

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            hcnt = 0;
        end else begin
            if (button) hcnt++;
            if (dice_done || light_done) begin
                chk("done_onehot", {31'd0, dice_done & light_done}, 0);
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("mode", {31'd0, dice_done}, {31'd0, e.dice});
                    chk("hold", hcnt, e.dice ? HD : HL);
                    if (e.dice) chk("dice_val", {29'd0, dice_val}, {29'd0, e.val});
                    else        chk("light_val", {29'd0, light_val}, {29'd0, e.val});
                end
                hcnt = 0;
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    // Cycle-accurate trace of one isolated session; starts at posedge+1
    task automatic trace(input logic d, input int h);
        push(d);
        if (d) dice_req = 1'b1; else light_req = 1'b1;
        @(posedge clk); #1;
        dice_req = 1'b0; light_req = 1'b0;
        for (int e = 1; e <= h + 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("sel_e%0d", e), {31'd0, sel}, {31'd0, d});
            chk($sformatf("btn_e%0d", e), {31'd0, button}, (e >= 2 && e <= h + 1) ? 1 : 0);
            chk($sformatf("done_e%0d", e), {31'd0, d ? dice_done : light_done}, (e == h + 3) ? 1 : 0);
        end
    endtask

    task automatic pulse_both();
        if (tb_last) begin push(1'b0); push(1'b1); end
        else         begin push(1'b1); push(1'b0); end
        dice_req = 1'b1; light_req = 1'b1;
        @(posedge clk); #1;
        dice_req = 1'b0; light_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", {31'd0, sel}, 0);
        chk("rst_button", {31'd0, button}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {30'd0, dice_done, light_done}, 0);
        chk("rst_vals", {26'd0, dice_val, light_val}, 0);
        rst = 1'b0;
        tb_last = 1'b0;
        @(posedge clk); #1;

        // Single dice session
        dice_res = 3'd4;
        trace(1'b1, HD);
        chk("dice_val_single", {29'd0, dice_val}, 4);
        chk("light_val_untouched", {29'd0, light_val}, 0);
        drain();

        // Single light session
        light_res = 3'b100;
        trace(1'b0, HL);
        chk("light_val_single", {29'd0, light_val}, 4);
        drain();

        // Contention right after a light grant: dice first
        dice_res = 3'd6; light_res = 3'd2;
        pulse_both();
        drain();
        // A lone dice session, then contention: light first
        dice_res = 3'd1;
        push(1'b1);
        dice_req = 1'b1; @(posedge clk); #1; dice_req = 1'b0;
        drain();
        dice_res = 3'd5; light_res = 3'd3;
        pulse_both();
        drain();

        // Merge: three dice pulses while a light session runs -> one dice session
        light_res = 3'd7; dice_res = 3'd2;
        push(1'b0);
        light_req = 1'b1; @(posedge clk); #1; light_req = 1'b0;
        push(1'b1);
        for (int i = 0; i < 3; i++) begin
            dice_req = 1'b1; @(posedge clk); #1; dice_req = 1'b0;
        end
        drain();

        // Requeue: a dice request during PRESS yields exactly one more session
        dice_res = 3'd3;
        push(1'b1);
        dice_req = 1'b1; @(posedge clk); #1; dice_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_press", {31'd0, button}, 1);
        push(1'b1);
        dice_req = 1'b1; @(posedge clk); #1; dice_req = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_busy", {31'd0, busy}, 0);

        // Reset on the 3rd button-high cycle, asserted between edges
        dice_res = 3'd6;
        push(1'b1);
        dice_req = 1'b1; @(posedge clk); #1; dice_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_button", {31'd0, button}, 1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_button", {31'd0, button}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_vals", {26'd0, dice_val, light_val}, 0);
        chk("async_sel", {31'd0, sel}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tb_last = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_vals", {26'd0, dice_val, light_val}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
